// File: rtl/tpu_top.sv
// Small TPU: C = A x B through a 4x4 output-stationary systolic array fed from word-addressed buffers.
// Optional SAT_EN: saturate result bytes to the signed 8-bit range instead of wrapping.

module tpu_gbuff #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] gbuff [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) gbuff[waddr] <= wdata;
    rdata <= gbuff[raddr];
  end
endmodule

module tpu_top #(
  parameter int DATA_W  = 8,
  parameter int ARRAY_N = 4,
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int ACC_W   = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] m,
  input  logic [3:0] k,
  input  logic [3:0] n,
  output logic       done
);
  localparam int          CNT_W = $clog2(16 + 2*ARRAY_N);
  localparam logic [3:0]  N_DIM = 4'(ARRAY_N);
  localparam int unsigned DRAIN = 2*(ARRAY_N-1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [3:0]       m_q, k_q, n_q;
  logic             rd_en, wr_en, pe_clr, rd_vld;
  logic [WORD_W-1:0] a_rdata, b_rdata, wr_word;

  logic [DATA_W-1:0] a_lane [ARRAY_N];
  logic [DATA_W-1:0] b_lane [ARRAY_N];
  logic [DATA_W-1:0] a_edge [ARRAY_N];
  logic [DATA_W-1:0] b_edge [ARRAY_N];
  logic [DATA_W-1:0] a_fwd  [ARRAY_N][ARRAY_N];
  logic [DATA_W-1:0] b_fwd  [ARRAY_N][ARRAY_N];
  logic [DATA_W-1:0] res    [ARRAY_N][ARRAY_N];

  function automatic logic [DATA_W-1:0] to_byte(input logic signed [ACC_W-1:0] v);
`ifdef SAT_EN
    logic signed [ACC_W-1:0] sat_max, sat_min;
    sat_max = ACC_W'((1 << (DATA_W-1)) - 1);
    sat_min = ~sat_max;
    if (v > sat_max)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (v < sat_min) return {1'b1, {(DATA_W-1){1'b0}}};
    else                  return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (k == 4'd0) ? COMPUTE : LOAD;
      LOAD:    if (cnt == CNT_W'(k_q) - CNT_W'(1)) state_nxt = COMPUTE;
      COMPUTE: if (cnt == CNT_W'(k_q) + CNT_W'(DRAIN))
                 state_nxt = (m_q == 4'd0) ? DONE : WRITE;
      WRITE:   if (cnt == CNT_W'(m_q) - CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en  = (state == LOAD);
    wr_en  = (state == WRITE);
    pe_clr = (state == IDLE);
    done   = (state == DONE);
  end

  // One counter spans LOAD+COMPUTE so the drain length is measured from the first read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      m_q <= '0;
      k_q <= '0;
      n_q <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (state == IDLE) begin
        cnt <= '0;
        if (start) begin
          m_q <= (m > N_DIM) ? N_DIM : m;
          n_q <= (n > N_DIM) ? N_DIM : n;
          k_q <= k;
        end
      end else if (state != DONE) begin
        cnt <= (state_nxt == WRITE && state != WRITE) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  tpu_gbuff #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) GBUFF_A (
    .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
    .raddr(ADDR_W'(cnt)), .rdata(a_rdata)
  );

  tpu_gbuff #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) GBUFF_B (
    .clk(clk), .we(1'b0), .waddr('0), .wdata('0),
    .raddr(ADDR_W'(cnt)), .rdata(b_rdata)
  );

  tpu_gbuff #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) GBUFF_OUT (
    .clk(clk), .we(wr_en), .waddr(ADDR_W'(cnt)), .wdata(wr_word),
    .raddr('0), .rdata()
  );

  for (genvar i = 0; i < ARRAY_N; i++) begin : g_skew
    assign a_lane[i] = rd_vld ? a_rdata[i*DATA_W +: DATA_W] : '0;
    assign b_lane[i] = rd_vld ? b_rdata[i*DATA_W +: DATA_W] : '0;
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_lane[i];
      assign b_edge[i] = b_lane[i];
    end else begin : g_delay
      logic [DATA_W-1:0] a_dly [i];
      logic [DATA_W-1:0] b_dly [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned j = 0; j < i; j++) begin
            a_dly[j] <= '0;
            b_dly[j] <= '0;
          end
        end else begin
          a_dly[0] <= a_lane[i];
          b_dly[0] <= b_lane[i];
          for (int unsigned j = 1; j < i; j++) begin
            a_dly[j] <= a_dly[j-1];
            b_dly[j] <= b_dly[j-1];
          end
        end
      end
      assign a_edge[i] = a_dly[i-1];
      assign b_edge[i] = b_dly[i-1];
    end
  end

  for (genvar r = 0; r < ARRAY_N; r++) begin : g_row
    for (genvar c = 0; c < ARRAY_N; c++) begin : g_pe
      logic [DATA_W-1:0]       ain, bin, a_q, b_q;
      logic signed [ACC_W-1:0] acc_q;

      if (c == 0) begin : g_ain_edge
        assign ain = a_edge[r];
      end else begin : g_ain_fwd
        assign ain = a_fwd[r][c-1];
      end
      if (r == 0) begin : g_bin_edge
        assign bin = b_edge[c];
      end else begin : g_bin_fwd
        assign bin = b_fwd[r-1][c];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else begin
          a_q <= ain;
          b_q <= bin;
          if (pe_clr) acc_q <= '0;
          else        acc_q <= acc_q + ACC_W'(signed'(ain)) * ACC_W'(signed'(bin));
        end
      end

      assign a_fwd[r][c] = a_q;
      assign b_fwd[r][c] = b_q;
      assign res[r][c]   = to_byte(acc_q);
    end
  end

  always_comb begin
    wr_word = '0;
    for (int unsigned r = 0; r < ARRAY_N; r++) begin
      if (cnt == CNT_W'(r)) begin
        for (int unsigned c = 0; c < ARRAY_N; c++) begin
          if (4'(c) < n_q) wr_word[c*DATA_W +: DATA_W] = res[r][c];
        end
      end
    end
  end
endmodule

// File: tb/tb_tpu_top.sv
// Directed bench for tpu_top: buffers preloaded hierarchically, expected output words queued per run.
module tb_tpu_top;
  logic       clk = 1'b0;
  logic       rst, start, done;
  logic [3:0] m, k, n;

  always #5 clk = ~clk;

  tpu_top #(.DATA_W(8), .ARRAY_N(4), .WORD_W(32), .ADDR_W(8), .ACC_W(20)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .k(k), .n(n), .done(done)
  );

  int          A_m [4][16];
  int          B_m [16][4];
  logic [31:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [7:0] res_byte(input int acc);
`ifdef SAT_EN
    if (acc > 127)  return 8'h7f;
    if (acc < -128) return 8'h80;
`endif
    return 8'(acc);
  endfunction

  function automatic logic [31:0] sentinel(input int i);
    return 32'hA5C3_0000 | 32'(i);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int t = 0; t < 16; t++)
      for (int l = 0; l < 4; l++) begin
        A_m[l][t] = int'($urandom_range(0, 255)) - 128;
        B_m[t][l] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic fill_const(input int v);
    for (int t = 0; t < 16; t++)
      for (int l = 0; l < 4; l++) begin
        A_m[l][t] = v;
        B_m[t][l] = v;
      end
  endtask

  task automatic load_bufs();
    logic [31:0] wa, wb;
    for (int t = 0; t < 16; t++) begin
      for (int l = 0; l < 4; l++) begin
        wa[l*8 +: 8] = 8'(A_m[l][t]);
        wb[l*8 +: 8] = 8'(B_m[t][l]);
      end
      dut.GBUFF_A.gbuff[t] = wa;
      dut.GBUFF_B.gbuff[t] = wb;
    end
    for (int i = 0; i < 8; i++) dut.GBUFF_OUT.gbuff[i] = sentinel(i);
  endtask

  task automatic push_expected(input int mm, input int kk, input int nn);
    int mc, nc, acc;
    logic [31:0] w;
    mc = (mm > 4) ? 4 : mm;
    nc = (nn > 4) ? 4 : nn;
    for (int i = 0; i < 8; i++) begin
      if (i < mc) begin
        w = '0;
        for (int c = 0; c < nc; c++) begin
          acc = 0;
          for (int t = 0; t < kk; t++) acc += A_m[i][t] * B_m[t][c];
          w[c*8 +: 8] = res_byte(acc);
        end
      end else begin
        w = sentinel(i);
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic check_out(input string tag);
    logic [31:0] obs, exp;
    for (int i = 0; i < 8; i++) begin
      exp = exp_q.pop_front();
      obs = dut.GBUFF_OUT.gbuff[i];
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s word%0d: observed=%h expected=%h", tag, i, obs, exp);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input string tag, input int mm, input int kk, input int nn);
    int lat, bound;
    push_expected(mm, kk, nn);
    bound = kk + 8 + ((mm > 4) ? 4 : mm) + 4;
    @(negedge clk);
    m = 4'(mm); k = 4'(kk); n = 4'(nn);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m = 4'd1; k = 4'd15; n = 4'd1;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_latency_within_bound"}, int'(lat <= bound), 1);
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m = '0; k = '0; n = '0;
    repeat (2) @(negedge clk);
    chk("done_in_reset", int'(done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_idle", int'(done), 0);

    for (int t = 0; t < 16; t++)
      for (int l = 0; l < 4; l++) begin
        A_m[l][t] = (t == l) ? 1 : 0;
        B_m[t][l] = (t < 4) ? t*4 + l + 1 : 0;
      end
    load_bufs();
    run_op("identity", 4, 4, 4);

    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_sticky", int'(done), 1);
    start = 1'b0;
    push_expected(4, 4, 4);
    check_out("sticky_no_rewrite");

    do_reset();
    chk("done_after_reset", int'(done), 0);
    fill_const(1);
    load_bufs();
    run_op("all_ones", 4, 4, 4);

    do_reset();
    fill_const(127);
    load_bufs();
    run_op("wrap_k15", 4, 15, 4);

    do_reset();
    fill_random();
    load_bufs();
    run_op("partial_m2_n3", 2, 4, 3);

    do_reset();
    fill_random();
    load_bufs();
    @(negedge clk);
    m = 4'd4; k = 4'd4; n = 4'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("done_mid_reset", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("rerun_after_reset", 4, 4, 4);

    do_reset();
    fill_random();
    load_bufs();
    run_op("k0", 4, 0, 4);

    do_reset();
    fill_random();
    load_bufs();
    run_op("m0", 0, 4, 4);

    do_reset();
    fill_random();
    load_bufs();
    run_op("clamp_m9_n12", 9, 7, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
